// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } debounce_state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_GLITCH_W        = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    // Shift the raw input through the flop chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean clock-synchronous level,
// flags open qualification windows and counts rejected bounces.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned GLITCH_W        = DEF_GLITCH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_in,
    output logic                btn_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            s;
    debounce_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic            btn_out_next;
    logic            busy_next;
    logic            glitch_inc;
    logic [GLITCH_W-1:0] glitch_next;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_in),
        .q  (s)
    );

    // State, counter and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            btn_out    <= 1'b0;
            busy       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            btn_out    <= btn_out_next;
            busy       <= busy_next;
            glitch_cnt <= glitch_next;
        end
    end

    // Next-state logic: open a window on a level change, qualify after
    // DEBOUNCE_CYCLES stable samples, abort and count a glitch otherwise.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        btn_out_next = btn_out;
        glitch_inc   = 1'b0;

        case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    glitch_inc = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_next   = IDLE_HIGH;
                    cnt_next     = '0;
                    btn_out_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    glitch_inc = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_next   = IDLE_LOW;
                    cnt_next     = '0;
                    btn_out_next = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next   = IDLE_LOW;
                cnt_next     = '0;
                btn_out_next = 1'b0;
            end
        endcase

        busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);

        glitch_next = glitch_cnt;
        if (glitch_inc && (glitch_cnt != '1)) begin
            glitch_next = glitch_cnt + GLITCH_W'(1);
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (2 sync stages,
// 4-cycle qualification, 2-bit glitch counter) plus a downstream
// pulse_generator stand-in fed by btn_out.
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       btn_out;
    logic       busy;
    logic [1:0] glitch_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Downstream rising-edge pulse generator: Q is one cycle wide.
    logic d_q = 1'b0;
    logic q   = 1'b0;

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .GLITCH_W       (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_out   (btn_out),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    // Registered edge detector on btn_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
            q   <= 1'b0;
        end else begin
            d_q <= btn_out;
            q   <= btn_out & ~d_q;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_in = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (btn_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_btn_out got=%b exp=0", btn_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        n_checks++;
        if (glitch_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_glitch got=%0d exp=0", glitch_cnt);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            n_checks++;
            if (btn_out !== (e >= 6)) begin
                n_fail++;
                $display("FAIL press_btn_out edge=%0d got=%b exp=%b", e, btn_out, (e >= 6));
            end
            n_checks++;
            if (busy !== (e >= 3 && e <= 5)) begin
                n_fail++;
                $display("FAIL press_busy edge=%0d got=%b exp=%b", e, busy, (e >= 3 && e <= 5));
            end
            n_checks++;
            if (glitch_cnt !== 2'd0) begin
                n_fail++;
                $display("FAIL press_glitch edge=%0d got=%0d exp=0", e, glitch_cnt);
            end
        end
    endtask

    task automatic test_short_bounce();
        logic [1:0] exp_g;
        do_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) btn_in = 1'b0;
            exp_g = (e >= 6) ? 2'd1 : 2'd0;
            n_checks++;
            if (btn_out !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_btn_out edge=%0d got=%b exp=0", e, btn_out);
            end
            n_checks++;
            if (busy !== (e >= 3 && e <= 5)) begin
                n_fail++;
                $display("FAIL bounce_busy edge=%0d got=%b exp=%b", e, busy, (e >= 3 && e <= 5));
            end
            n_checks++;
            if (glitch_cnt !== exp_g) begin
                n_fail++;
                $display("FAIL bounce_glitch edge=%0d got=%0d exp=%0d", e, glitch_cnt, exp_g);
            end
        end
    endtask

    task automatic test_glitch_saturation();
        logic [1:0] exp_g;
        do_reset();
        for (int b = 1; b <= 5; b++) begin
            btn_in = 1'b1;
            repeat (3) tick();
            btn_in = 1'b0;
            repeat (6) tick();
            exp_g = (b >= 3) ? 2'd3 : 2'(b);
            n_checks++;
            if (glitch_cnt !== exp_g) begin
                n_fail++;
                $display("FAIL sat_glitch bounce=%0d got=%0d exp=%0d", b, glitch_cnt, exp_g);
            end
            n_checks++;
            if (btn_out !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_btn_out bounce=%0d got=%b exp=0", b, btn_out);
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        btn_in = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (btn_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_pressed got=%b exp=1", btn_out);
        end
        // 2-cycle low glitch while high
        btn_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 2) btn_in = 1'b1;
            n_checks++;
            if (btn_out !== 1'b1) begin
                n_fail++;
                $display("FAIL rel_glitch_btn_out edge=%0d got=%b exp=1", e, btn_out);
            end
        end
        n_checks++;
        if (glitch_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL rel_glitch_cnt got=%0d exp=1", glitch_cnt);
        end
        // Real release
        btn_in = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (btn_out !== (e < 6)) begin
                n_fail++;
                $display("FAIL rel_btn_out edge=%0d got=%b exp=%b", e, btn_out, (e < 6));
            end
            n_checks++;
            if (busy !== (e >= 3 && e <= 5)) begin
                n_fail++;
                $display("FAIL rel_busy edge=%0d got=%b exp=%b", e, busy, (e >= 3 && e <= 5));
            end
        end
        n_checks++;
        if (glitch_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL rel_final_glitch got=%0d exp=1", glitch_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        btn_in = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_open got=%b exp=1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_busy got=%b exp=0", busy);
        end
        n_checks++;
        if (glitch_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL midwait_glitch got=%0d exp=0", glitch_cnt);
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (btn_out !== (e >= 6)) begin
                n_fail++;
                $display("FAIL midwait_btn_out edge=%0d got=%b exp=%b", e, btn_out, (e >= 6));
            end
        end
        n_checks++;
        if (glitch_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL midwait_glitch_end got=%0d exp=0", glitch_cnt);
        end
    endtask

    task automatic test_chained_pulse();
        int unsigned pulses;
        pulses = 0;
        do_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            btn_in = (e == 1) ? 1'b0 : 1'b1;
            if (q === 1'b1) pulses++;
            n_checks++;
            if (q !== (e == 9)) begin
                n_fail++;
                $display("FAIL chain_q edge=%0d got=%b exp=%b", e, q, (e == 9));
            end
            n_checks++;
            if (btn_out !== (e >= 8)) begin
                n_fail++;
                $display("FAIL chain_btn_out edge=%0d got=%b exp=%b", e, btn_out, (e >= 8));
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL chain_pulse_count got=%0d exp=1", pulses);
        end
        n_checks++;
        if (glitch_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL chain_glitch got=%0d exp=1", glitch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_short_bounce();
        test_glitch_saturation();
        test_release();
        test_reset_mid_wait();
        test_chained_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
